vga_scanout: RTL and testbench
==============================

# vga_scanout

Consumer end of the pixel FIFO that the frame-buffer loader fills. It pops one 24-bit pixel per visible pixel-clock tick and generates 640x480 VGA timing: hsync, vsync, blank and registered RGB. Pixels are consumed in raster order, one per visible pixel, left to right and top to bottom. This matches the order in which the loader pushes its 8x8-replicated 80x60 image.

## Interface
Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch
- H_SYNC, 96, hsync pulse width
- H_BACK, 48, horizontal back porch
- V_VISIBLE, 480, visible lines
- V_FRONT, 10, vertical front porch
- V_SYNC, 2, vsync width in lines
- V_BACK, 33, vertical back porch

Ports:
- clk  in  1  system clock
- rst  in  1  reset; one clock; reset is synchronous and active-low
- pix_en  in  1  pixel-clock enable; all timing advances only on cycles with pix_en=1
- fifo_dout  in  24  FIFO read data; valid the clk after fifo_rd_en
- fifo_empty  in  1  FIFO empty
- fifo_full  in  1  FIFO full; used only for priming
- fifo_rd_en  out  1  pop strobe, single-cycle
- rgb  out  24  {R[7:0],G[7:0],B[7:0]}; 0 whenever blanked
- hsync  out  1  active-low horizontal sync
- vsync  out  1  active-low vertical sync
- blank  out  1  1 outside the visible area
- frame_start  out  1  one-clk pulse when pixel (0,0) is presented on the outputs
- underrun  out  1  sticky; set when a visible pixel finds the FIFO empty

## Operation
- Two states: PRIME and RUN.
  - After reset: PRIME.
  - PRIME to RUN on the first clk with fifo_full=1 and pix_en=1.
  - RUN persists until reset.
  - In PRIME: counters held at 0, fifo_rd_en=0, outputs at reset values.
- Counters, both widths ceil(log2(total)):
  - h_cnt runs 0..H_total-1, with H_total = sum of the H parameters (800).
  - v_cnt runs 0..V_total-1 (525).
  - h_cnt increments on each pix_en in RUN and wraps to 0.
  - v_cnt increments when h_cnt wraps; v_cnt wraps to 0 after 524.
- Decode at counter stage, registered into a one-deep pipe:
  - visible = h_cnt<H_VISIBLE && v_cnt<V_VISIBLE
  - hs = !(H_VISIBLE+H_FRONT <= h_cnt < H_VISIBLE+H_FRONT+H_SYNC), i.e. low for h_cnt 656..751
  - vs = low for v_cnt 490..491
- fifo_rd_en = RUN & pix_en & visible & !fifo_empty.
- The pipe records `popped` = fifo_rd_en alongside visible/hs/vs/first, where first = (h_cnt==0 && v_cnt==0).
- Output register, updated on pix_en cycles only:
  - rgb <= (pipe.visible & pipe.popped) ? fifo_dout : 0
  - blank <= !pipe.visible; hsync <= pipe.hs; vsync <= pipe.vs
  - frame_start <= pipe.first & pix_en, so it is high for exactly one clk
- Underrun:
  - If visible & pix_en & fifo_empty in RUN: underrun <= 1, no pop, and that pixel outputs black.
  - Raster timing never stalls.
  - Underrun is cleared only by reset.
- No pops occur in blanking. Exactly 307200 pops occur per frame when there is no underrun.

## Timing
- Reset values (rst=0 at a clk edge, takes effect that edge):
  - rgb=0, hsync=1, vsync=1, blank=1, frame_start=0, underrun=0, fifo_rd_en=0
  - state=PRIME, counters=0, pipe cleared (visible=0, hs=1, vs=1)
- Reset mid-frame:
  - Same values on the next edge.
  - Any outstanding fifo_dout is ignored.
  - The block re-primes before scanning again.
- Latency: two pix_en ticks from counter value to pins.
  - Tick k: counter = (h,v); pop issued.
  - Tick k+1: outputs show pixel (h,v).
  - Sync and blank are delayed identically, so they stay aligned with rgb.
- FIFO contract: standard (not FWFT) read, 1-clk data latency. fifo_dout must hold until the next fifo_rd_en. This holds for pix_en continuously 1 or any duty cycle.
- fifo_empty is sampled in the same clk as the pop decision; no speculative pops.
- Simultaneous events:
  - fifo_full rising in the same clk as reset release: ignored until the next edge.
  - End-of-line wrap and end-of-frame wrap coincide at (799,524), giving next (0,0).

## Test plan
- Reset, then hold fifo_full=0 for 100 pix_en -> fifo_rd_en never asserts; hsync=vsync=1, blank=1, rgb=0.
- Prime, pix_en=1 continuously, FIFO always non-empty with incrementing data -> per line:
  - exactly 640 pops
  - blank low for 640 clks
  - hsync low for 96 clks, starting 16 clks after blank rises
  - rgb equals the popped sequence with a 1-clk offset from pop
- Full frame at pix_en 1-in-4 -> 420000 (800x525) pix_en ticks between frame_start pulses; vsync low for 1600 ticks (2 lines); 307200 pops.
- Force fifo_empty=1 for visible pixel (10,3) -> no pop that tick; rgb=0 at that pixel; underrun=1 and stays 1 through the following frames; pixel (11,3) shows the next FIFO word.
- Assert rst=0 at (h=300,v=200) for 1 clk -> all outputs at reset values next edge; no pops until fifo_full=1 again; first frame_start occurs 2 pix_en ticks after RUN entry.
- Counter wrap: run to (799,524) -> next tick is (0,0); frame_start pulses for exactly 1 clk; no pop in blanking around the wrap.

Source files
------------

// File: rtl/vga_scanout_if.sv
// Read side of the pixel FIFO that sits between the frame-buffer loader and the VGA scanout.
interface vga_scanout_if;
    logic [23:0] fifo_dout;
    logic        fifo_empty;
    logic        fifo_full;
    logic        fifo_rd_en;

    // Standard (non-FWFT) read: fifo_rd_en pulses for one clk only while fifo_empty=0;
    // fifo_dout carries that word from the next clk and holds it until the next pop.
    modport master (input fifo_dout, fifo_empty, fifo_full, output fifo_rd_en);
    modport slave  (output fifo_dout, fifo_empty, fifo_full, input fifo_rd_en);
endinterface

// File: rtl/vga_scanout.sv
// VGA raster generator that drains the pixel FIFO one word per visible pixel.
// Counter-stage decode feeds a one-deep pipe so sync/blank stay aligned with the popped RGB.
module vga_scanout #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pix_en,
    vga_scanout_if.master fifo,
    output logic [23:0]   rgb,
    output logic          hsync,
    output logic          vsync,
    output logic          blank,
    output logic          frame_start,
    output logic          underrun,
    output logic          state_dbg
);
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS_N  = HW'(H_VISIBLE);
    localparam logic [HW-1:0] HS_BEGIN = HW'(H_VISIBLE + H_FRONT);
    localparam logic [HW-1:0] HS_END   = HW'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [HW-1:0] H_ONE    = HW'(1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_VIS_N  = VW'(V_VISIBLE);
    localparam logic [VW-1:0] VS_BEGIN = VW'(V_VISIBLE + V_FRONT);
    localparam logic [VW-1:0] VS_END   = VW'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [VW-1:0] V_ONE    = VW'(1);

    typedef enum logic {PRIME = 1'b0, RUN = 1'b1} state_t;

    state_t        state_q, state_d;
    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          visible, hs, vs, first, tick;
    logic          p_visible, p_popped, p_hs, p_vs, p_first;

    assign visible   = (h_cnt < H_VIS_N) && (v_cnt < V_VIS_N);
    assign hs        = !((h_cnt >= HS_BEGIN) && (h_cnt < HS_END));
    assign vs        = !((v_cnt >= VS_BEGIN) && (v_cnt < VS_END));
    assign first     = (h_cnt == '0) && (v_cnt == '0);
    assign tick      = (state_q == RUN) && pix_en;
    assign state_dbg = (state_q == RUN);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= PRIME;
        end else begin
            state_q <= state_d;
        end
    end

    // Pops are decided on the live fifo_empty; an empty FIFO never stalls the raster.
    always_comb begin
        state_d         = state_q;
        fifo.fifo_rd_en = 1'b0;
        case (state_q)
            PRIME: if (fifo.fifo_full && pix_en) state_d = RUN;
            RUN:   fifo.fifo_rd_en = pix_en && visible && !fifo.fifo_empty;
            default: state_d = PRIME;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (tick) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + V_ONE;
            end else begin
                h_cnt <= h_cnt + H_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            p_visible <= 1'b0;
            p_popped  <= 1'b0;
            p_hs      <= 1'b1;
            p_vs      <= 1'b1;
            p_first   <= 1'b0;
        end else if (tick) begin
            p_visible <= visible;
            p_popped  <= fifo.fifo_rd_en;
            p_hs      <= hs;
            p_vs      <= vs;
            p_first   <= first;
        end
    end

    // fifo_dout belongs to the pop recorded in the pipe; it is held until the next pop.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rgb         <= '0;
            blank       <= 1'b1;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            frame_start <= tick && p_first;
            if (tick) begin
                rgb   <= (p_visible && p_popped) ? fifo.fifo_dout : '0;
                blank <= !p_visible;
                hsync <= p_hs;
                vsync <= p_vs;
            end
            if (tick && visible && fifo.fifo_empty) underrun <= 1'b1;
        end
    end
endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout on a reduced raster (30x15 total, 16x8 visible) so whole frames stay short.
module tb_vga_scanout;
    localparam int H_VIS = 16, H_FP = 3, H_SY = 5, H_BP = 6;
    localparam int V_VIS = 8,  V_FP = 2, V_SY = 2, V_BP = 3;
    localparam int H_TOT = H_VIS + H_FP + H_SY + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SY + V_BP;
    localparam int FRAME = H_TOT * V_TOT;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pix_en = 1'b0;
    logic [23:0] rgb;
    logic        hsync, vsync, blank, frame_start, underrun, state_dbg;

    vga_scanout_if bus();

    vga_scanout #(
        .H_VISIBLE(H_VIS), .H_FRONT(H_FP), .H_SYNC(H_SY), .H_BACK(H_BP),
        .V_VISIBLE(V_VIS), .V_FRONT(V_FP), .V_SYNC(V_SY), .V_BACK(V_BP)
    ) dut (
        .clk(clk), .rst(rst), .pix_en(pix_en), .fifo(bus),
        .rgb(rgb), .hsync(hsync), .vsync(vsync), .blank(blank),
        .frame_start(frame_start), .underrun(underrun), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    int   checks = 0, failures = 0;
    int   seed, dut_pops = 0, m_pops = 0, pos = 0;
    logic m_run = 1'b0, last_rd = 1'b0;
    logic [23:0] p_rgb, e_rgb;
    logic p_blank, p_hs, p_vs, p_first;
    logic e_blank, e_hs, e_vs, e_fs, e_under;

    // FIFO contents: word k of the stream is a seeded hash of k.
    function automatic logic [23:0] word(input int k);
        logic [31:0] t;
        t = ((32'(k) + 32'd1) * 32'h9E3779B1) ^ 32'(seed);
        return t[23:0];
    endfunction

    function automatic logic hs_at(input int h);
        return !(h >= H_VIS + H_FP && h < H_VIS + H_FP + H_SY);
    endfunction

    function automatic logic vs_at(input int v);
        return !(v >= V_VIS + V_FP && v < V_VIS + V_FP + V_SY);
    endfunction

    // Non-FWFT FIFO read port: the popped word appears the clk after fifo_rd_en.
    always @(posedge clk) begin
        if (bus.fifo_rd_en === 1'b1) begin
            bus.fifo_dout <= word(dut_pops);
            dut_pops++;
        end
    end

    task automatic model_reset();
        m_run = 1'b0; pos = 0;
        p_rgb = '0; p_blank = 1'b1; p_hs = 1'b1; p_vs = 1'b1; p_first = 1'b0;
        e_rgb = '0; e_blank = 1'b1; e_hs = 1'b1; e_vs = 1'b1; e_fs = 1'b0; e_under = 1'b0;
    endtask

    // One clk: drive inputs, check the pop decision, advance the raster model, check the pins.
    task automatic tick(input logic en, input logic empty, input logic full);
        int h, v;
        logic vis, exp_rd;
        pix_en = en; bus.fifo_empty = empty; bus.fifo_full = full;
        #1;
        h = pos % H_TOT; v = pos / H_TOT;
        vis = (h < H_VIS) && (v < V_VIS);
        exp_rd = m_run && en && vis && !empty;
        last_rd = bus.fifo_rd_en;
        checks++;
        if (bus.fifo_rd_en !== exp_rd) begin
            failures++; $display("FAIL rd_en pos=%0d got %b expected %b", pos, bus.fifo_rd_en, exp_rd);
        end
        checks++;
        if (state_dbg !== m_run) begin
            failures++; $display("FAIL state got %b expected %b", state_dbg, m_run);
        end
        @(posedge clk);
        e_fs = 1'b0;
        if (m_run && en) begin
            e_rgb = p_rgb; e_blank = p_blank; e_hs = p_hs; e_vs = p_vs; e_fs = p_first;
            p_blank = !vis; p_hs = hs_at(h); p_vs = vs_at(v); p_first = (pos == 0);
            p_rgb = '0;
            if (vis && !empty) begin
                p_rgb = word(m_pops);
                m_pops++;
            end
            if (vis && empty) e_under = 1'b1;
            pos = (pos + 1) % FRAME;
        end else if (!m_run && en && full) begin
            m_run = 1'b1;
        end
        #1;
        checks++;
        if (rgb !== e_rgb) begin failures++; $display("FAIL rgb got %h expected %h", rgb, e_rgb); end
        checks++;
        if (blank !== e_blank) begin failures++; $display("FAIL blank got %b expected %b", blank, e_blank); end
        checks++;
        if (hsync !== e_hs) begin failures++; $display("FAIL hsync got %b expected %b", hsync, e_hs); end
        checks++;
        if (vsync !== e_vs) begin failures++; $display("FAIL vsync got %b expected %b", vsync, e_vs); end
        checks++;
        if (frame_start !== e_fs) begin failures++; $display("FAIL frame_start got %b expected %b", frame_start, e_fs); end
        checks++;
        if (underrun !== e_under) begin failures++; $display("FAIL underrun got %b expected %b", underrun, e_under); end
    endtask

    task automatic run_to(input int target);
        int g = 0;
        while (pos != target && g < 2 * FRAME) begin
            tick(1'b1, 1'b0, 1'b0);
            g++;
        end
        checks++;
        if (pos != target) begin failures++; $display("FAIL run_to got pos %0d expected %0d", pos, target); end
    endtask

    task automatic test_reset();
        rst = 1'b0; pix_en = 1'b0; bus.fifo_empty = 1'b0; bus.fifo_full = 1'b0;
        @(posedge clk); #1;
        model_reset();
        rst = 1'b1;
        checks++;
        if (rgb !== 24'h0 || blank !== 1'b1 || hsync !== 1'b1 || vsync !== 1'b1) begin
            failures++; $display("FAIL reset_pins got rgb=%h b=%b h=%b v=%b expected 0 1 1 1", rgb, blank, hsync, vsync);
        end
        checks++;
        if (frame_start !== 1'b0 || underrun !== 1'b0 || state_dbg !== 1'b0) begin
            failures++; $display("FAIL reset_flags got fs=%b ur=%b st=%b expected 0 0 0", frame_start, underrun, state_dbg);
        end
        for (int i = 0; i < 100; i++) tick(1'b1, 1'(($urandom_range(0, 1))), 1'b0);
    endtask

    task automatic test_frame(input int period);
        int c = 0, g = 0, ticks = 0, pops = 0, line_pops = 0;
        int blank_lo = 0, hs_lo = 0, vs_lo = 0, t_rise = -1, t_fall = -1, hs_run = 0;
        logic en, prev_blank, prev_hs, hs_done;
        if (!m_run) tick(1'b1, 1'b0, 1'b1);
        while (frame_start !== 1'b1 && g < 3 * FRAME * period) begin
            en = (c % period == 0); tick(en, 1'b0, 1'b0); c++; g++;
        end
        checks++;
        if (frame_start !== 1'b1) begin failures++; $display("FAIL frame_start_timeout got 0 expected 1"); end
        prev_blank = blank; prev_hs = hsync; hs_done = 1'b0; g = 0;
        do begin
            en = (c % period == 0); tick(en, 1'b0, 1'b0); c++; g++;
            if (en) begin
                ticks++;
                if (last_rd) begin pops++; if (ticks <= H_TOT) line_pops++; end
                if (!blank) blank_lo++;
                if (!hsync) hs_lo++;
                if (!vsync) vs_lo++;
                if (t_rise < 0 && !prev_blank && blank) t_rise = ticks;
                if (t_rise >= 0 && t_fall < 0 && prev_hs && !hsync) t_fall = ticks;
                if (t_fall >= 0 && !hs_done) begin
                    if (!hsync) hs_run++; else hs_done = 1'b1;
                end
                prev_blank = blank; prev_hs = hsync;
            end
        end while (frame_start !== 1'b1 && g < 2 * FRAME * period);
        checks++;
        if (ticks != FRAME) begin failures++; $display("FAIL frame_ticks got %0d expected %0d", ticks, FRAME); end
        checks++;
        if (pops != H_VIS * V_VIS) begin failures++; $display("FAIL frame_pops got %0d expected %0d", pops, H_VIS * V_VIS); end
        checks++;
        if (line_pops != H_VIS) begin failures++; $display("FAIL line_pops got %0d expected %0d", line_pops, H_VIS); end
        checks++;
        if (blank_lo != H_VIS * V_VIS) begin failures++; $display("FAIL blank_low got %0d expected %0d", blank_lo, H_VIS * V_VIS); end
        checks++;
        if (hs_lo != H_SY * V_TOT) begin failures++; $display("FAIL hsync_low got %0d expected %0d", hs_lo, H_SY * V_TOT); end
        checks++;
        if (vs_lo != V_SY * H_TOT) begin failures++; $display("FAIL vsync_low got %0d expected %0d", vs_lo, V_SY * H_TOT); end
        checks++;
        if (t_fall - t_rise != H_FP) begin failures++; $display("FAIL hsync_offset got %0d expected %0d", t_fall - t_rise, H_FP); end
        checks++;
        if (hs_run != H_SY) begin failures++; $display("FAIL hsync_width got %0d expected %0d", hs_run, H_SY); end
        en = (c % period == 0); tick(en, 1'b0, 1'b0);
        checks++;
        if (frame_start !== 1'b0) begin failures++; $display("FAIL frame_start_width got 1 expected 0"); end
    endtask

    task automatic test_wrap();
        run_to(FRAME - 1);
        tick(1'b1, 1'b0, 1'b0);
        checks++;
        if (last_rd !== 1'b0) begin failures++; $display("FAIL wrap_blank_pop got %b expected 0", last_rd); end
        tick(1'b1, 1'b0, 1'b0);
        checks++;
        if (last_rd !== 1'b1) begin failures++; $display("FAIL wrap_origin_pop got %b expected 1", last_rd); end
        tick(1'b1, 1'b0, 1'b0);
        checks++;
        if (frame_start !== 1'b1) begin failures++; $display("FAIL wrap_frame_start got %b expected 1", frame_start); end
        tick(1'b0, 1'b0, 1'b0);
        checks++;
        if (frame_start !== 1'b0) begin failures++; $display("FAIL wrap_fs_pulse got %b expected 0", frame_start); end
    endtask

    task automatic test_underrun();
        int k;
        run_to(3 * H_TOT + 10);
        k = m_pops;
        tick(1'b1, 1'b1, 1'b0);
        checks++;
        if (last_rd !== 1'b0 || underrun !== 1'b1) begin
            failures++; $display("FAIL underrun_set got rd=%b ur=%b expected 0 1", last_rd, underrun);
        end
        tick(1'b1, 1'b0, 1'b0);
        checks++;
        if (rgb !== 24'h0 || blank !== 1'b0) begin
            failures++; $display("FAIL underrun_black got rgb=%h blank=%b expected 0 0", rgb, blank);
        end
        tick(1'b1, 1'b0, 1'b0);
        checks++;
        if (rgb !== word(k)) begin failures++; $display("FAIL underrun_next got %h expected %h", rgb, word(k)); end
        for (int i = 0; i < 2 * FRAME; i++) tick(1'($urandom_range(0, 1)), 1'b0, 1'b0);
        checks++;
        if (underrun !== 1'b1) begin failures++; $display("FAIL underrun_sticky got %b expected 1", underrun); end
    endtask

    task automatic test_mid_reset();
        int n = 0, pops = 0;
        run_to(5 * H_TOT + 9);
        rst = 1'b0; pix_en = 1'b1; bus.fifo_full = 1'b1; bus.fifo_empty = 1'b1;
        @(posedge clk); #1;
        model_reset();
        rst = 1'b1;
        checks++;
        if (rgb !== 24'h0 || blank !== 1'b1 || hsync !== 1'b1 || vsync !== 1'b1) begin
            failures++; $display("FAIL midreset_pins got rgb=%h b=%b h=%b v=%b expected 0 1 1 1", rgb, blank, hsync, vsync);
        end
        checks++;
        if (frame_start !== 1'b0 || underrun !== 1'b0 || state_dbg !== 1'b0) begin
            failures++; $display("FAIL midreset_flags got fs=%b ur=%b st=%b expected 0 0 0", frame_start, underrun, state_dbg);
        end
        for (int i = 0; i < 20; i++) begin
            tick(1'b1, 1'($urandom_range(0, 1)), 1'b0);
            if (last_rd) pops++;
        end
        checks++;
        if (pops != 0) begin failures++; $display("FAIL midreset_pops got %0d expected 0", pops); end
        tick(1'b1, 1'b0, 1'b1);
        while (frame_start !== 1'b1 && n < 10) begin
            tick(1'b1, 1'b0, 1'b0);
            n++;
        end
        checks++;
        if (n != 2) begin failures++; $display("FAIL reprime_latency got %0d expected 2", n); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++)
            tick(1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)));
    endtask

    initial begin
        seed = int'($urandom);
        bus.fifo_empty = 1'b0;
        bus.fifo_full = 1'b0;
        model_reset();
        test_reset();
        test_frame(1);
        test_frame(4);
        test_wrap();
        test_underrun();
        test_mid_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
